// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit:
//   - MDU_OP_* : 3-bit operation encodings driven by the decoder
//   - MDU_MULT_CYCLES / MDU_DIV_CYCLES : default busy latencies
//   - mdu_cnt_width() / MDU_CNT_W : width of the latency countdown
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;
    localparam logic [2:0] MDU_OP_NONE7 = 3'd7;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // The counter has to hold the larger latency, so it needs
    // clog2(max + 1) bits.
    function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(mx + 1);
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_width(MDU_MULT_CYCLES, MDU_DIV_CYCLES);

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
// Purely combinational multiply/divide datapath.
// Ports:
//   op       in  3  MDU_OP_* encoding; only MULT/MULTU/DIV/DIVU produce results
//   a        in 32  multiplicand / dividend
//   b        in 32  multiplier / divisor
//   res_hi   out 32 product[63:32] or remainder
//   res_lo   out 32 product[31:0]  or quotient
//   div_zero out 1  divide op with b == 0 (result must not be committed)
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Low 64 bits of a product of sign-extended operands equal the signed
    // 32x32 product, so both flavours share one plain multiplier form.
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // Signed divide works on magnitudes. INT_MIN has magnitude 0x80000000,
    // which still fits in 32 unsigned bits, so INT_MIN / -1 yields quotient
    // magnitude 0x80000000 that wraps back to 0x80000000 with no special case.
    assign signed_div = (op == MDU_OP_DIV);
    assign a_mag  = (signed_div && a[31]) ? (32'd0 - a) : a;
    assign b_mag  = (signed_div && b[31]) ? (32'd0 - b) : b;
    // Keep the divider away from a zero divisor; the result is discarded then.
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign q_fix = (signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    assign r_fix = (signed_div && a[31])           ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (op)
            MDU_OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
                res_hi   = r_fix;
                res_lo   = q_fix;
                div_zero = (b == 32'd0);
            end
            default: begin
                res_hi   = 32'd0;
                res_lo   = 32'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// The 64-bit result is computed at accept time and held in pending
// registers; a countdown models the fixed latency and HI/LO are written on
// the edge where the countdown reaches zero.
// Ports:
//   clk      in  1  clock
//   reset    in  1  synchronous active-high reset
//   start    in  1  EX instruction is an MDU op this cycle
//   op       in  3  MDU_OP_* encoding
//   rs_data  in 32  dividend / multiplicand / MTHI-MTLO source
//   rt_data  in 32  divisor / multiplier
//   block    in  1  suppress this cycle's op (exception pending downstream)
//   busy     out 1  registered; high while a MULT/DIV is in flight
//   hi       out 32 architectural HI
//   lo       out 32 architectural LO
// ---------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        block,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic             accept;
    logic             commit;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_zero;

    mdu_arith u_arith (
        .op       (op),
        .a        (rs_data),
        .b        (rt_data),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    // NONE encodings (0 and 7) never count as an accepted op.
    assign accept = start && !block && !busy_q &&
                    (op >= MDU_OP_MULT) && (op <= MDU_OP_MTLO);
    assign commit = (count_q == CNT_W'(1));

    always_comb begin
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end

        if (commit && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end

        // accept requires !busy_q, so it can never coincide with a commit.
        if (accept) begin
            case (op)
                MDU_OP_MULT, MDU_OP_MULTU: begin
                    count_d   = CNT_W'(MULT_CYCLES);
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = 1'b1;
                end
                MDU_OP_DIV, MDU_OP_DIVU: begin
                    count_d   = CNT_W'(DIV_CYCLES);
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    // Divide by zero still spends the full latency but
                    // leaves HI/LO untouched at commit.
                    pend_wr_d = !div_zero;
                end
                MDU_OP_MTHI: hi_d = rs_data;
                MDU_OP_MTLO: lo_d = rs_data;
                default: begin
                    count_d = count_q;
                end
            endcase
        end

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu
// Self-checking bench for mdu: directed cases from the test plan followed by
// randomized ops, all checked against a reference model built on 64-bit
// integer arithmetic. Inputs change and outputs are sampled on the falling
// edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_mdu;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        block;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int hazard_cnt = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .block   (block),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    // Flags any MDU op issued while the unit is busy (a hazard-unit violation).
    always @(posedge clk) begin
        if (!reset && start && busy) begin
            hazard_cnt++;
            $display("note: start asserted while busy at %0t", $time);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Reference model: architectural effect of one accepted op on (h, l).
    task automatic ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] h, inout logic [31:0] l);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (o)
            3'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd2: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
            3'd4: if (b != 0) begin q = ua / ub; r = ua % ub; h = r[31:0]; l = q[31:0]; end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endtask

    // Issue one op (called on a falling edge with busy low), follow it to
    // completion and check latency and HI/LO. inject>0 drives a MULT start
    // during that busy cycle to exercise the ignore-while-busy path.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic blk, input int inject);
        int n;
        int want_n;
        logic [31:0] nh, nl;
        bit acc;
        acc = !blk && (o >= 3'd1) && (o <= 3'd6);
        nh = exp_hi;
        nl = exp_lo;
        if (acc) ref_op(o, a, b, nh, nl);
        want_n = (acc && o <= 3'd2) ? N_MULT : (acc && o <= 3'd4) ? N_DIV : 0;

        start = 1'b1; op = o; rs_data = a; rt_data = b; block = blk;
        @(negedge clk);
        start = 1'b0; op = 3'd0; block = 1'b0;

        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            chk({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, exp_hi});
            chk({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, exp_lo});
            if (n == inject) begin
                start = 1'b1; op = 3'd1; rs_data = 32'h0000_0003; rt_data = 32'h0000_0003;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; op = 3'd0;

        exp_hi = nh;
        exp_lo = nl;
        chk({tag, "_busy_cycles"}, 64'(n), 64'(want_n));
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        $display("op=%0d a=%08h b=%08h blk=%0b busy_cycles=%0d hi=%08h lo=%08h  [%s]",
                 o, a, b, blk, n, hi, lo, tag);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(0, 20));
            4: v = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0; block = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases with constants worked out by hand.
        do_op("mult", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0);
        chk("mult_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo_const", {32'd0, lo}, 64'hFFFF_FFFE);
        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0);
        chk("multu_hi_const", {32'd0, hi}, 64'h0000_0001);
        chk("multu_lo_const", {32'd0, lo}, 64'hFFFF_FFFE);
        do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 0);
        chk("div_neg_lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_neg_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
        do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        chk("div_ovf_lo_const", {32'd0, lo}, 64'h8000_0000);
        chk("div_ovf_hi_const", {32'd0, hi}, 64'h0000_0000);
        do_op("divu_zero", 3'd4, 32'h0000_0007, 32'h0000_0000, 1'b0, 0);
        chk("divu_zero_lo_const", {32'd0, lo}, 64'h8000_0000);
        do_op("mthi", 3'd5, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 0);
        chk("mthi_hi_const", {32'd0, hi}, 64'h0000_1234);
        chk("mthi_lo_const", {32'd0, lo}, 64'h8000_0000);
        do_op("mtlo_blocked", 3'd6, 32'h5555_AAAA, 32'd0, 1'b1, 0);
        chk("mtlo_blocked_lo_const", {32'd0, lo}, 64'h8000_0000);
        do_op("op7_none", 3'd7, 32'h1111_1111, 32'd1, 1'b0, 0);

        // Start of a MULT in busy cycle 2 of a DIV must be ignored.
        do_op("div_hazard", 3'd3, 32'd100, 32'd7, 1'b0, 2);
        chk("div_hazard_lo_const", {32'd0, lo}, 64'd14);
        chk("div_hazard_hi_const", {32'd0, hi}, 64'd2);
        chk("hazard_flagged", 64'(hazard_cnt), 64'd1);

        // Reset in busy cycle 3 of a DIV: clears state, no later commit.
        start = 1'b1; op = 3'd3; rs_data = 32'd1000; rt_data = 32'd3; block = 1'b0;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        chk("rst_mid_busy1", {63'd0, busy}, 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo}, 64'd0);
        repeat (N_DIV + 3) @(negedge clk);
        chk("rst_no_commit_hi", {32'd0, hi}, 64'd0);
        chk("rst_no_commit_lo", {32'd0, lo}, 64'd0);
        chk("rst_no_commit_busy", {63'd0, busy}, 64'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            logic        rblk;
            ro   = 3'($urandom_range(0, 7));
            ra   = pick_operand();
            rb   = pick_operand();
            rblk = ($urandom_range(0, 4) == 0);
            do_op($sformatf("rand%0d", i), ro, ra, rb, rblk, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
